// File: rtl/mat_pkg.sv
// Shared definitions for the matrix add/sub engine.
// Op encodings, FSM state type and element index helper.
package mat_pkg;

    localparam logic [1:0] OP_SUB     = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b01;
    localparam logic [1:0] OP_ACC_ADD = 2'b10;
    localparam logic [1:0] OP_ACC_SUB = 2'b11;

    typedef enum logic {
        IDLE,
        COMPUTE
    } state_t;

    function automatic int elemIdx(input int i, input int j,
                                   input int n, input int w);
        return (i * n + j) * w;
    endfunction

endpackage

// File: rtl/mat_elem_alu.sv
// One element of the add/sub datapath.
// Computes at W+2 bits, then saturates or wraps back to W.
module mat_elem_alu
    import mat_pkg::*;
#(
    parameter int W   = 16,
    parameter bit SAT = 1'b0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] r,
    input  logic [1:0]   op,
    output logic [W-1:0] res,
    output logic         ovf
);

    localparam int XW = W + 2;
    localparam logic signed [XW-1:0] MAXV = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [XW-1:0] MINV = {3'b111, {(W-1){1'b0}}};

    logic signed [XW-1:0] ax;
    logic signed [XW-1:0] bx;
    logic signed [XW-1:0] rx;
    logic signed [XW-1:0] full;
    logic                 isSub;
    logic                 isAcc;

    // Wide sum of the sign-extended operands, then range reduction.
    always_comb begin
        ax    = {{2{a[W-1]}}, a};
        bx    = {{2{b[W-1]}}, b};
        rx    = {{2{r[W-1]}}, r};
        isSub = (op == OP_SUB) || (op == OP_ACC_SUB);
        isAcc = (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
        full  = isAcc ? rx + ax : ax;
        if (isSub) begin
            full = full - bx;
        end else begin
            full = full + bx;
        end
        res = full[W-1:0];
        ovf = 1'b0;
        if (SAT) begin
            if (full > MAXV) begin
                res = MAXV[W-1:0];
                ovf = 1'b1;
            end else if (full < MINV) begin
                res = MINV[W-1:0];
                ovf = 1'b1;
            end
        end else begin
            ovf = (full != {{2{full[W-1]}}, full[W-1:0]});
        end
    end

endmodule

// File: rtl/mat_addsub_engine.sv
// Row-serial N x N matrix add/sub with accumulate.
// LANES rows of the result are produced per COMPUTE cycle.
module mat_addsub_engine
    import mat_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 16,
    parameter int LANES = 1,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*N*W-1:0] data_in,
    input  logic             enable,
    input  logic             rw,
    input  logic             mat_sel,
    input  logic [1:0]       op,
    input  logic             acc_clr,
    output logic [N*N*W-1:0] data_out,
    output logic             flag,
    output logic             busy,
    output logic             ovf,
    output logic             cmd_drop
);

    localparam int MW   = N * N * W;
    localparam int CW   = $clog2(N);
    localparam int LAST = N - LANES;

    state_t                 state;
    state_t                 nextState;
    logic [MW-1:0]          aReg;
    logic [MW-1:0]          bReg;
    logic [MW-1:0]          rReg;
    logic [1:0]             opReg;
    logic [CW-1:0]          cnt;
    logic [LANES*N*W-1:0]   resVec;
    logic [LANES*N-1:0]     ovfVec;
    logic                   lastGroup;
    logic                   doClr;
    logic                   doWrA;
    logic                   doWrB;
    logic                   doRd;

    assign lastGroup = (cnt == CW'(LAST));
    assign doClr = acc_clr;
    assign doWrA = !acc_clr && enable && rw && !mat_sel;
    assign doWrB = !acc_clr && enable && rw && mat_sel;
    assign doRd  = !acc_clr && enable && !rw;

    for (genvar l = 0; l < LANES; l++) begin : gLane
        for (genvar j = 0; j < N; j++) begin : gCol
            int base;
            assign base = elemIdx(int'(cnt) + l, j, N, W);
            mat_elem_alu #(
                .W   (W),
                .SAT (SAT)
            ) uAlu (
                .a   (aReg[base +: W]),
                .b   (bReg[base +: W]),
                .r   (rReg[base +: W]),
                .op  (opReg),
                .res (resVec[(l*N+j)*W +: W]),
                .ovf (ovfVec[l*N+j])
            );
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state: B write starts compute, last row group ends it.
    always_comb begin
        nextState = state;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (doWrB) begin
                    nextState = COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (lastGroup) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Command execution in IDLE, row-group writeback in COMPUTE.
    always_ff @(posedge clk) begin
        if (rst) begin
            aReg     <= '0;
            bReg     <= '0;
            rReg     <= '0;
            opReg    <= OP_SUB;
            cnt      <= '0;
            data_out <= '0;
            flag     <= 1'b0;
            ovf      <= 1'b0;
            cmd_drop <= 1'b0;
        end else begin
            flag     <= 1'b0;
            cmd_drop <= 1'b0;
            if (state == IDLE) begin
                unique case (1'b1)
                    doClr: begin
                        rReg <= '0;
                        flag <= 1'b1;
                    end
                    doWrA: begin
                        aReg <= data_in;
                        flag <= 1'b1;
                    end
                    doWrB: begin
                        bReg  <= data_in;
                        opReg <= op;
                        ovf   <= 1'b0;
                        cnt   <= '0;
                    end
                    doRd: begin
                        data_out <= rReg;
                        flag     <= 1'b1;
                    end
                    default: ;
                endcase
            end else begin
                cmd_drop <= enable || acc_clr;
                for (int l = 0; l < LANES; l++) begin
                    for (int j = 0; j < N; j++) begin
                        rReg[elemIdx(int'(cnt) + l, j, N, W) +: W]
                            <= resVec[(l*N+j)*W +: W];
                    end
                end
                ovf  <= ovf || (|ovfVec);
                cnt  <= cnt + CW'(LANES);
                flag <= lastGroup;
            end
        end
    end

endmodule

// File: tb/tb_mat_addsub_engine.sv
// Self-checking bench for mat_addsub_engine (4x4x16, one lane).
// Wrap and saturating instances share the same stimulus.
module tb_mat_addsub_engine;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MW = N * N * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [MW-1:0] data_in = '0;
    logic          enable = 1'b0;
    logic          rw = 1'b0;
    logic          mat_sel = 1'b0;
    logic [1:0]    op = 2'b00;
    logic          acc_clr = 1'b0;

    logic [MW-1:0] dataOut;
    logic          flag, busy, ovf, cmdDrop;
    logic [MW-1:0] dataOutS;
    logic          flagS, busyS, ovfS, cmdDropS;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mat_addsub_engine #(.N(N), .W(W), .LANES(1), .SAT(1'b0)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .enable(enable),
        .rw(rw), .mat_sel(mat_sel), .op(op), .acc_clr(acc_clr),
        .data_out(dataOut), .flag(flag), .busy(busy), .ovf(ovf),
        .cmd_drop(cmdDrop)
    );

    mat_addsub_engine #(.N(N), .W(W), .LANES(1), .SAT(1'b1)) dutS (
        .clk(clk), .rst(rst), .data_in(data_in), .enable(enable),
        .rw(rw), .mat_sel(mat_sel), .op(op), .acc_clr(acc_clr),
        .data_out(dataOutS), .flag(flagS), .busy(busyS), .ovf(ovfS),
        .cmd_drop(cmdDropS)
    );

    typedef struct {
        logic        clr;
        logic [15:0] aVal;
        logic [15:0] bVal;
        logic [1:0]  opV;
        logic [15:0] expW;
        logic        ovfW;
        logic [15:0] expS;
        logic        ovfS;
    } vec_t;

    typedef struct {
        logic [MW-1:0] d0;
        logic [MW-1:0] dS;
    } rd_t;

    rd_t expQ[$];

    function automatic logic [MW-1:0] fill(input logic [15:0] v);
        logic [MW-1:0] r;
        for (int i = 0; i < N * N; i++) r[i*W +: W] = v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [MW-1:0] act,
                       input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic en, input logic rwV, input logic sel,
                         input logic clr, input logic [1:0] opV,
                         input logic [MW-1:0] d);
        @(negedge clk);
        enable  = en;
        rw      = rwV;
        mat_sel = sel;
        acc_clr = clr;
        op      = opV;
        data_in = d;
        @(negedge clk);
        enable  = 1'b0;
        acc_clr = 1'b0;
    endtask

    task automatic doRead(input string name, input logic [MW-1:0] e0,
                          input logic [MW-1:0] eS);
        rd_t item;
        rd_t got;
        item.d0 = e0;
        item.dS = eS;
        expQ.push_back(item);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, '0);
        chk({name, "_flag"}, MW'(flag), MW'(1));
        if (flag && expQ.size() > 0) begin
            got = expQ.pop_front();
            chk(name, dataOut, got.d0);
            chk({name, "_sat"}, dataOutS, got.dS);
        end
    endtask

    task automatic runB(input string name, input logic [MW-1:0] d,
                        input logic [1:0] opV);
        int lat;
        int busyCnt;
        issue(1'b1, 1'b1, 1'b1, 1'b0, opV, d);
        lat = 1;
        busyCnt = 0;
        while (!flag && lat < 20) begin
            if (busy) busyCnt++;
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, MW'(lat), MW'(5));
        chk({name, "_busycyc"}, MW'(busyCnt), MW'(4));
        chk({name, "_busyoff"}, MW'(busy), MW'(0));
    endtask

    vec_t vecs[7];
    logic [MW-1:0] m;

    initial begin
        vecs[0] = '{1'b0, 16'h0005, 16'h0003, 2'b01, 16'h0008, 1'b0, 16'h0008, 1'b0};
        vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 2'b01, 16'h8000, 1'b1, 16'h7FFF, 1'b1};
        vecs[2] = '{1'b0, 16'h0002, 16'h0007, 2'b00, 16'hFFFB, 1'b0, 16'hFFFB, 1'b0};
        vecs[3] = '{1'b0, 16'h8000, 16'h0001, 2'b00, 16'h7FFF, 1'b1, 16'h8000, 1'b1};
        vecs[4] = '{1'b1, 16'h0001, 16'h0001, 2'b10, 16'h0002, 1'b0, 16'h0002, 1'b0};
        vecs[5] = '{1'b0, 16'h0001, 16'h0001, 2'b10, 16'h0004, 1'b0, 16'h0004, 1'b0};
        vecs[6] = '{1'b0, 16'h0003, 16'h0001, 2'b11, 16'h0006, 1'b0, 16'h0006, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_data", dataOut, '0);
        chk("rst_flags", MW'({flag, busy, ovf, cmdDrop}), MW'(0));

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].clr) begin
                issue(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, '0);
                chk($sformatf("v%0d_clrflag", v), MW'(flag), MW'(1));
            end
            issue(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, fill(vecs[v].aVal));
            chk($sformatf("v%0d_aflag", v), MW'(flag), MW'(1));
            runB($sformatf("v%0d", v), fill(vecs[v].bVal), vecs[v].opV);
            chk($sformatf("v%0d_ovf", v), MW'(ovf), MW'(vecs[v].ovfW));
            chk($sformatf("v%0d_ovfsat", v), MW'(ovfS), MW'(vecs[v].ovfS));
            doRead($sformatf("v%0d_rd", v), fill(vecs[v].expW),
                   fill(vecs[v].expS));
        end

        // Single nonzero element: only R(0,0) changes.
        m = '0;
        m[15:0] = 16'h0002;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, m);
        m[15:0] = 16'h0007;
        runB("sub00", m, 2'b00);
        chk("sub00_ovf", MW'(ovf), MW'(0));
        m[15:0] = 16'hFFFB;
        doRead("sub00_rd", m, m);

        issue(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, '0);
        chk("clr_flag", MW'(flag), MW'(1));
        doRead("clr_rd", '0, '0);

        // Commands while busy are dropped.
        issue(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, fill(16'h0005));
        issue(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, fill(16'h0003));
        enable = 1'b1;
        rw     = 1'b0;
        @(negedge clk);
        chk("drop_rd_pulse", MW'(cmdDrop), MW'(1));
        chk("drop_rd_flag", MW'(flag), MW'(0));
        chk("drop_rd_data", dataOut, '0);
        rw      = 1'b1;
        mat_sel = 1'b0;
        data_in = fill(16'h0009);
        @(negedge clk);
        chk("drop_a_pulse", MW'(cmdDrop), MW'(1));
        chk("drop_a_flag", MW'(flag), MW'(0));
        enable = 1'b0;
        @(negedge clk);
        chk("drop_idle", MW'(cmdDrop), MW'(0));
        begin
            int k;
            k = 0;
            while (!flag && k < 10) begin
                @(negedge clk);
                k++;
            end
            chk("drop_done_cyc", MW'(k), MW'(1));
        end
        doRead("drop_rd1", fill(16'h0008), fill(16'h0008));
        runB("drop_b2", fill(16'h0003), 2'b01);
        doRead("drop_rd2", fill(16'h0008), fill(16'h0008));

        // Reset in the middle of COMPUTE.
        issue(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, fill(16'h0001));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", MW'(busy), MW'(0));
        chk("mrst_flag", MW'(flag), MW'(0));
        chk("mrst_data", dataOut, '0);
        repeat (6) begin
            @(negedge clk);
            chk("mrst_noflag", MW'(flag), MW'(0));
        end
        doRead("mrst_rd", '0, '0);

        chk("q_empty", MW'(expQ.size()), MW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
